png_chunk_crc_seq: RTL and testbench

//  Parametrised PNG chunk CRC sequencer; generalises the fixed 32-bit IDAT/IHDR/IEND CRC top.

---
 rtl/png_chunk_crc_seq.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_png_chunk_crc_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/png_chunk_crc_seq.sv
// ---------------------------------------------------------------------------
// png_chunk_crc_seq
//   PNG chunk CRC sequencer. For each frame it emits a length + CRC32 result
//   for IHDR, optionally sRGB, one or more IDAT chunks (split every
//   IDAT_MAX_BYTES payload bytes), and finally IEND, in PNG file order.
//   Contains its own byte-serial / beat-wide CRC32 engine (reflected poly
//   0xEDB88320, init 0xFFFFFFFF, result inverted).
//
//   Optional feature macro: PNG_CRC_SRGB_CHUNK_EN -- when defined an sRGB
//   chunk (rendering intent 0) is emitted between IHDR and the first IDAT.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   w_i, h_i             image width / height, sampled on accepted start_i
//   bit_dep_i, clr_typ_i IHDR bit depth / colour type, sampled with start_i
//   start_i              begin a frame (accepted only while busy_o==0)
//   val_i,dat_i,num_i    IDAT payload beat, MSB byte first, num_i = bytes-1
//   lst_i                last payload beat of the frame
//   rdy_o                payload beat accepted when val_i && rdy_o
//   busy_o               frame in progress
//   val_o                one-cycle pulse: typ_o/len_o/crc_o valid
//   typ_o                0 IHDR, 1 sRGB, 2 IDAT, 3 IEND
//   len_o, crc_o         chunk data length, chunk CRC32 (type + data)
//   done_o               pulses together with the IEND result
// ---------------------------------------------------------------------------
module png_chunk_crc_seq #(
   parameter int DATA_WD        = 32,
   parameter int NUM_WD         = 2,
   parameter int SIZE_W_WD      = 10,
   parameter int SIZE_H_WD      = 10,
   parameter int IDAT_MAX_BYTES = 8192
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [SIZE_W_WD-1:0] w_i,
   input  logic [SIZE_H_WD-1:0] h_i,
   input  logic [7:0]           bit_dep_i,
   input  logic [7:0]           clr_typ_i,
   input  logic                 start_i,
   input  logic                 val_i,
   input  logic [DATA_WD-1:0]   dat_i,
   input  logic [NUM_WD-1:0]    num_i,
   input  logic                 lst_i,
   output logic                 rdy_o,
   output logic                 busy_o,
   output logic                 val_o,
   output logic [1:0]           typ_o,
   output logic [31:0]          len_o,
   output logic [31:0]          crc_o,
   output logic                 done_o
);

   localparam int NB = DATA_WD / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DTYP,
      S_DAT,
      S_GAP,
      S_END
`ifdef PNG_CRC_SRGB_CHUNK_EN
      , S_SRGB
`endif
   } state_t;

   state_t        r_state;
   state_t        r_nxt;     // state entered after the inter-chunk gap cycle
   logic [4:0]    r_idx;     // byte index within the fixed-byte phases
   logic [31:0]   r_cnt;     // IDAT payload bytes absorbed in current chunk
   logic [31:0]   r_crc;
   logic [SIZE_W_WD-1:0] r_w;
   logic [SIZE_H_WD-1:0] r_h;
   logic [7:0]    r_bd;
   logic [7:0]    r_ct;
   logic          r_val;
   logic [1:0]    r_typ;
   logic [31:0]   r_len;
   logic [31:0]   r_res;
   logic          r_done;

   logic [7:0]    w_byte;
   logic [31:0]   w_crc_b;
   logic [31:0]   w_beat_crc;
   logic [31:0]   w_cnt_nxt;
   logic [31:0]   w_w32;
   logic [31:0]   w_h32;
   logic          w_full;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int unsigned k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign w_w32     = 32'(r_w);
   assign w_h32     = 32'(r_h);
   assign w_cnt_nxt = r_cnt + 32'(num_i) + 32'd1;
   assign w_full    = (num_i == NUM_WD'(NB - 1));

   // Byte fed to the CRC engine in the fixed-content phases.
   always_comb begin
      w_byte = '0;
      case (r_state)
         S_HDR: begin
            case (r_idx)
               5'd0:    w_byte = 8'h49;
               5'd1:    w_byte = 8'h48;
               5'd2:    w_byte = 8'h44;
               5'd3:    w_byte = 8'h52;
               5'd4:    w_byte = w_w32[31:24];
               5'd5:    w_byte = w_w32[23:16];
               5'd6:    w_byte = w_w32[15:8];
               5'd7:    w_byte = w_w32[7:0];
               5'd8:    w_byte = w_h32[31:24];
               5'd9:    w_byte = w_h32[23:16];
               5'd10:   w_byte = w_h32[15:8];
               5'd11:   w_byte = w_h32[7:0];
               5'd12:   w_byte = r_bd;
               5'd13:   w_byte = r_ct;
               default: w_byte = '0;
            endcase
         end
         S_DTYP: begin
            case (r_idx[1:0])
               2'd0:    w_byte = 8'h49;
               2'd1:    w_byte = 8'h44;
               2'd2:    w_byte = 8'h41;
               default: w_byte = 8'h54;
            endcase
         end
         S_END: begin
            case (r_idx[1:0])
               2'd0:    w_byte = 8'h49;
               2'd1:    w_byte = 8'h45;
               2'd2:    w_byte = 8'h4E;
               default: w_byte = 8'h44;
            endcase
         end
`ifdef PNG_CRC_SRGB_CHUNK_EN
         S_SRGB: begin
            case (r_idx)
               5'd0:    w_byte = 8'h73;
               5'd1:    w_byte = 8'h52;
               5'd2:    w_byte = 8'h47;
               5'd3:    w_byte = 8'h42;
               default: w_byte = 8'h00;
            endcase
         end
`endif
         default: w_byte = '0;
      endcase
   end

   assign w_crc_b = crc_byte(r_crc, w_byte);

   // Beat-wide CRC: absorb num_i+1 bytes starting from the MSB byte.
   always_comb begin
      w_beat_crc = r_crc;
      for (int unsigned i = 0; i < NB; i++) begin
         if (i <= 32'(num_i))
            w_beat_crc = crc_byte(w_beat_crc, dat_i[DATA_WD-1-8*i -: 8]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_nxt   <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_crc   <= '1;
         r_w     <= '0;
         r_h     <= '0;
         r_bd    <= '0;
         r_ct    <= '0;
         r_val   <= 1'b0;
         r_typ   <= '0;
         r_len   <= '0;
         r_res   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_val  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_w     <= w_i;
                  r_h     <= h_i;
                  r_bd    <= bit_dep_i;
                  r_ct    <= clr_typ_i;
                  r_idx   <= '0;
                  r_cnt   <= '0;
                  r_crc   <= '1;
                  r_state <= S_HDR;
               end
            end
            S_HDR: begin
               if (r_idx == 5'd16) begin
                  r_val   <= 1'b1;
                  r_typ   <= 2'd0;
                  r_len   <= 32'd13;
                  r_res   <= ~w_crc_b;
                  r_crc   <= '1;
                  r_idx   <= '0;
                  r_state <= S_GAP;
`ifdef PNG_CRC_SRGB_CHUNK_EN
                  r_nxt   <= S_SRGB;
`else
                  r_nxt   <= S_DTYP;
`endif
               end else begin
                  r_crc <= w_crc_b;
                  r_idx <= r_idx + 5'd1;
               end
            end
`ifdef PNG_CRC_SRGB_CHUNK_EN
            S_SRGB: begin
               if (r_idx == 5'd4) begin
                  r_val   <= 1'b1;
                  r_typ   <= 2'd1;
                  r_len   <= 32'd1;
                  r_res   <= ~w_crc_b;
                  r_crc   <= '1;
                  r_idx   <= '0;
                  r_state <= S_GAP;
                  r_nxt   <= S_DTYP;
               end else begin
                  r_crc <= w_crc_b;
                  r_idx <= r_idx + 5'd1;
               end
            end
`endif
            S_DTYP: begin
               r_crc <= w_crc_b;
               if (r_idx == 5'd3) begin
                  r_idx   <= '0;
                  r_state <= S_DAT;
               end else begin
                  r_idx <= r_idx + 5'd1;
               end
            end
            S_DAT: begin
               if (val_i) begin
                  if (lst_i) begin
                     // Last beat always closes the chunk, so a payload that
                     // lands exactly on the limit never yields an empty IDAT.
                     r_val   <= 1'b1;
                     r_typ   <= 2'd2;
                     r_len   <= w_cnt_nxt;
                     r_res   <= ~w_beat_crc;
                     r_crc   <= '1;
                     r_cnt   <= '0;
                     r_state <= S_GAP;
                     r_nxt   <= S_END;
                  end else if (w_full && (w_cnt_nxt == 32'(IDAT_MAX_BYTES))) begin
                     r_val   <= 1'b1;
                     r_typ   <= 2'd2;
                     r_len   <= 32'(IDAT_MAX_BYTES);
                     r_res   <= ~w_beat_crc;
                     r_crc   <= '1;
                     r_cnt   <= '0;
                     r_state <= S_GAP;
                     r_nxt   <= S_DTYP;
                  end else begin
                     r_crc <= w_beat_crc;
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
            S_GAP: begin
               r_idx   <= '0;
               r_state <= r_nxt;
            end
            S_END: begin
               if (r_idx == 5'd3) begin
                  r_val   <= 1'b1;
                  r_done  <= 1'b1;
                  r_typ   <= 2'd3;
                  r_len   <= 32'd0;
                  r_res   <= ~w_crc_b;
                  r_crc   <= '1;
                  r_idx   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_crc <= w_crc_b;
                  r_idx <= r_idx + 5'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rdy_o  = (r_state == S_DAT);
   assign busy_o = (r_state != S_IDLE);
   assign val_o  = r_val;
   assign typ_o  = r_typ;
   assign len_o  = r_len;
   assign crc_o  = r_res;
   assign done_o = r_done;

endmodule

// File: tb/tb_png_chunk_crc_seq.sv
module tb_png_chunk_crc_seq;

   localparam int DW   = 32;
   localparam int NW   = 2;
   localparam int MAXB = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [9:0]    w_i;
   logic [9:0]    h_i;
   logic [7:0]    bit_dep_i;
   logic [7:0]    clr_typ_i;
   logic          start_i;
   logic          val_i;
   logic [DW-1:0] dat_i;
   logic [NW-1:0] num_i;
   logic          lst_i;
   logic          rdy_o;
   logic          busy_o;
   logic          val_o;
   logic [1:0]    typ_o;
   logic [31:0]   len_o;
   logic [31:0]   crc_o;
   logic          done_o;

   png_chunk_crc_seq #(
      .DATA_WD(DW), .NUM_WD(NW), .SIZE_W_WD(10), .SIZE_H_WD(10),
      .IDAT_MAX_BYTES(MAXB)
   ) dut (
      .clk(clk), .rstn(rstn), .w_i(w_i), .h_i(h_i),
      .bit_dep_i(bit_dep_i), .clr_typ_i(clr_typ_i), .start_i(start_i),
      .val_i(val_i), .dat_i(dat_i), .num_i(num_i), .lst_i(lst_i),
      .rdy_o(rdy_o), .busy_o(busy_o), .val_o(val_o), .typ_o(typ_o),
      .len_o(len_o), .crc_o(crc_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  typ;
      logic [31:0] len;
      logic [31:0] crc;
      logic        done;
   } res_t;

   typedef logic [7:0] bq_t[$];

   res_t        got_q[$];
   res_t        exp_q[$];
   logic [31:0] beat_d[$];
   logic [1:0]  last_num;
   logic [31:0] crc_tab[256];
   int          n_pass  = 0;
   int          n_total = 0;

   // Table-driven CRC32 over a whole byte string.
   function automatic logic [31:0] crc_of(input bq_t b);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
      return ~c;
   endfunction

   always @(negedge clk)
      if (rstn && val_o) got_q.push_back('{typ_o, len_o, crc_o, done_o});

   // Expected chunk list for one frame from the image header and payload.
   task automatic model_frame(input logic [9:0] w, input logic [9:0] h,
                              input logic [7:0] bd, input logic [7:0] ct);
      bq_t b;
      bq_t p;
      int  off, n;
      exp_q.delete();
      b = '{8'h49, 8'h48, 8'h44, 8'h52, 8'h00, 8'h00, 8'(w >> 8), w[7:0],
            8'h00, 8'h00, 8'(h >> 8), h[7:0], bd, ct, 8'h00, 8'h00, 8'h00};
      exp_q.push_back('{2'd0, 32'd13, crc_of(b), 1'b0});
`ifdef PNG_CRC_SRGB_CHUNK_EN
      b = '{8'h73, 8'h52, 8'h47, 8'h42, 8'h00};
      exp_q.push_back('{2'd1, 32'd1, crc_of(b), 1'b0});
`endif
      foreach (beat_d[j]) begin
         n = (j == beat_d.size() - 1) ? int'(last_num) + 1 : 4;
         for (int k = 0; k < n; k++) p.push_back(beat_d[j][31-8*k -: 8]);
      end
      off = 0;
      while (off < p.size()) begin
         n = (p.size() - off > MAXB) ? MAXB : p.size() - off;
         b = '{8'h49, 8'h44, 8'h41, 8'h54};
         for (int k = 0; k < n; k++) b.push_back(p[off + k]);
         exp_q.push_back('{2'd2, 32'(n), crc_of(b), 1'b0});
         off += n;
      end
      b = '{8'h49, 8'h45, 8'h4E, 8'h44};
      exp_q.push_back('{2'd3, 32'd0, crc_of(b), 1'b1});
   endtask

   // Drives one frame from beat_d/last_num; poke pulses start_i while stalled.
   task automatic run_frame(input logic [9:0] w, input logic [9:0] h,
                            input logic [7:0] bd, input logic [7:0] ct,
                            input bit poke, output bit ok);
      int g;
      ok = 1'b1;
      got_q.delete();
      @(negedge clk);
      w_i = w; h_i = h; bit_dep_i = bd; clr_typ_i = ct;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      foreach (beat_d[j]) begin
         val_i = 1'b1;
         dat_i = beat_d[j];
         lst_i = (j == beat_d.size() - 1);
         num_i = lst_i ? last_num : 2'd3;
         g = 0;
         while (!rdy_o && g < 200) begin
            if (poke) start_i = 1'b1;
            @(negedge clk);
            g++;
         end
         start_i = 1'b0;
         if (g >= 200) ok = 1'b0;
         @(negedge clk);
      end
      val_i = 1'b0; lst_i = 1'b0;
      g = 0;
      while (busy_o && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) ok = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if ({val_o, typ_o, len_o, crc_o, done_o, busy_o, rdy_o} !== '0)
         $display("FAIL reset_outputs: got val=%b typ=%0d len=%0d crc=%h done=%b busy=%b rdy=%b, need all 0",
                  val_o, typ_o, len_o, crc_o, done_o, busy_o, rdy_o);
      else n_pass++;
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      bit ok;
      beat_d = '{32'hDEAD_BEEF};
      last_num = 2'd3;
      model_frame(10'd640, 10'd480, 8'd8, 8'd6);
      run_frame(10'd640, 10'd480, 8'd8, 8'd6, 1'b0, ok);
      n_total++;
      if (!ok) $display("FAIL basic_timeout: frame did not complete"); else n_pass++;
      n_total++;
      if (got_q.size() !== exp_q.size())
         $display("FAIL basic_count: got %0d results, need %0d", got_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL basic_chunk%0d: got typ=%0d len=%0d crc=%h done=%b need typ=%0d len=%0d crc=%h done=%b",
                     i, got_q[i].typ, got_q[i].len, got_q[i].crc, got_q[i].done,
                     exp_q[i].typ, exp_q[i].len, exp_q[i].crc, exp_q[i].done);
         else n_pass++;
      end
      if (got_q.size() > 0) begin
         n_total++;
         if (got_q[got_q.size()-1].crc !== 32'hAE42_6082)
            $display("FAIL iend_crc: got %h need AE426082", got_q[got_q.size()-1].crc);
         else n_pass++;
      end
`ifdef PNG_CRC_SRGB_CHUNK_EN
      if (got_q.size() > 1) begin
         n_total++;
         if (got_q[1].typ !== 2'd1 || got_q[1].len !== 32'd1 || got_q[1].crc !== 32'hAECE_1CE9)
            $display("FAIL srgb_chunk: got typ=%0d len=%0d crc=%h need typ=1 len=1 crc=AECE1CE9",
                     got_q[1].typ, got_q[1].len, got_q[1].crc);
         else n_pass++;
      end
`endif
   endtask

   // max 8: 3 full beats + 2-byte last beat -> IDAT 8, IDAT 6
   task automatic test_split;
      bit ok;
      beat_d.delete();
      repeat (4) beat_d.push_back($urandom);
      last_num = 2'd1;
      model_frame(10'd17, 10'd3, 8'd8, 8'd2);
      run_frame(10'd17, 10'd3, 8'd8, 8'd2, 1'b0, ok);
      n_total++;
      if (!ok || got_q.size() !== exp_q.size())
         $display("FAIL split_count: got %0d results ok=%b, need %0d", got_q.size(), ok, exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL split_chunk%0d: got typ=%0d len=%0d crc=%h need typ=%0d len=%0d crc=%h",
                     i, got_q[i].typ, got_q[i].len, got_q[i].crc,
                     exp_q[i].typ, exp_q[i].len, exp_q[i].crc);
         else n_pass++;
      end
   endtask

   // Exactly the limit on the last beat: one IDAT of 8, no empty IDAT.
   task automatic test_exact;
      bit ok;
      int n_idat;
      beat_d = '{$urandom, $urandom};
      last_num = 2'd3;
      model_frame(10'd1, 10'd1, 8'd1, 8'd0);
      run_frame(10'd1, 10'd1, 8'd1, 8'd0, 1'b0, ok);
      n_idat = 0;
      foreach (got_q[i]) if (got_q[i].typ == 2'd2) n_idat++;
      n_total++;
      if (!ok || n_idat !== 1)
         $display("FAIL exact_idat_count: got %0d IDAT results ok=%b, need 1", n_idat, ok);
      else n_pass++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL exact_chunk%0d: got typ=%0d len=%0d crc=%h need typ=%0d len=%0d crc=%h",
                     i, got_q[i].typ, got_q[i].len, got_q[i].crc,
                     exp_q[i].typ, exp_q[i].len, exp_q[i].crc);
         else n_pass++;
      end
   endtask

   // val_i held through non-ready phases and start_i pulsed while busy.
   task automatic test_holds;
      bit ok;
      got_q.delete();
      @(negedge clk);
      val_i = 1'b1; lst_i = 1'b1; dat_i = $urandom; num_i = 2'd3;
      repeat (5) @(negedge clk);
      val_i = 1'b0; lst_i = 1'b0;
      n_total++;
      if (got_q.size() !== 0 || busy_o !== 1'b0)
         $display("FAIL idle_val_ignored: got %0d results busy=%b, need 0 results busy=0", got_q.size(), busy_o);
      else n_pass++;
      beat_d.delete();
      repeat (5) beat_d.push_back($urandom);
      last_num = 2'd2;
      model_frame(10'd999, 10'd1023, 8'd16, 8'd2);
      run_frame(10'd999, 10'd1023, 8'd16, 8'd2, 1'b1, ok);
      n_total++;
      if (!ok || got_q.size() !== exp_q.size())
         $display("FAIL holds_count: got %0d results ok=%b, need %0d", got_q.size(), ok, exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL holds_chunk%0d: got typ=%0d len=%0d crc=%h need typ=%0d len=%0d crc=%h",
                     i, got_q[i].typ, got_q[i].len, got_q[i].crc,
                     exp_q[i].typ, exp_q[i].len, exp_q[i].crc);
         else n_pass++;
      end
   endtask

   task automatic test_reset_middat;
      bit ok;
      int acc, g;
      got_q.delete();
      @(negedge clk);
      w_i = 10'd5; h_i = 10'd6; bit_dep_i = 8'd8; clr_typ_i = 8'd0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      acc = 0; g = 0;
      val_i = 1'b1; lst_i = 1'b0; num_i = 2'd3;
      while (acc < 3 && g < 300) begin
         dat_i = $urandom;
         if (rdy_o) acc++;
         @(negedge clk);
         g++;
      end
      val_i = 1'b0;
      rstn = 1'b0;
      #1;
      n_total++;
      if ({val_o, typ_o, len_o, crc_o, done_o, busy_o, rdy_o} !== '0 || acc !== 3)
         $display("FAIL middat_reset: got val=%b typ=%0d len=%0d crc=%h done=%b busy=%b rdy=%b beats=%0d, need all 0 after 3 beats",
                  val_o, typ_o, len_o, crc_o, done_o, busy_o, rdy_o, acc);
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      beat_d = '{$urandom, $urandom, $urandom};
      last_num = 2'd0;
      model_frame(10'd5, 10'd6, 8'd8, 8'd0);
      run_frame(10'd5, 10'd6, 8'd8, 8'd0, 1'b0, ok);
      n_total++;
      if (!ok || got_q.size() !== exp_q.size())
         $display("FAIL middat_after_count: got %0d results ok=%b, need %0d", got_q.size(), ok, exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) if (i < got_q.size()) begin
         n_total++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL middat_after_chunk%0d: got typ=%0d len=%0d crc=%h need typ=%0d len=%0d crc=%h",
                     i, got_q[i].typ, got_q[i].len, got_q[i].crc,
                     exp_q[i].typ, exp_q[i].len, exp_q[i].crc);
         else n_pass++;
      end
   endtask

   task automatic test_random;
      bit ok;
      logic [9:0] w, h;
      logic [7:0] bd, ct;
      for (int f = 0; f < 20; f++) begin
         w = 10'($urandom); h = 10'($urandom);
         bd = 8'($urandom); ct = 8'($urandom);
         beat_d.delete();
         repeat ($urandom_range(1, 7)) beat_d.push_back($urandom);
         last_num = 2'($urandom);
         model_frame(w, h, bd, ct);
         run_frame(w, h, bd, ct, f[0], ok);
         n_total++;
         if (!ok || got_q.size() !== exp_q.size())
            $display("FAIL rand%0d_count: got %0d results ok=%b, need %0d", f, got_q.size(), ok, exp_q.size());
         else n_pass++;
         foreach (exp_q[i]) if (i < got_q.size()) begin
            n_total++;
            if (got_q[i] !== exp_q[i])
               $display("FAIL rand%0d_chunk%0d: got typ=%0d len=%0d crc=%h done=%b need typ=%0d len=%0d crc=%h done=%b",
                        f, i, got_q[i].typ, got_q[i].len, got_q[i].crc, got_q[i].done,
                        exp_q[i].typ, exp_q[i].len, exp_q[i].crc, exp_q[i].done);
            else n_pass++;
         end
      end
   endtask

   initial begin
      logic [31:0] c;
      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         crc_tab[n] = c;
      end
      rstn = 1'b0; start_i = 1'b0; val_i = 1'b0; lst_i = 1'b0;
      dat_i = '0; num_i = '0; w_i = '0; h_i = '0; bit_dep_i = '0; clr_typ_i = '0;
      test_reset;
      test_basic;
      test_split;
      test_exact;
      test_holds;
      test_reset_middat;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
